seg7_frame_decoder: RTL and testbench
=====================================

SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, sets the consecutive identical samples required before a digit is captured (legal range 2..255).
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 seg_in  input  7  active-low segment cathodes; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-005 an_in  input  4  active-low digit anodes; an_in[3]=leftmost digit (value[15:12]), an_in[0]=rightmost (value[3:0]).
REQ-006 value  output  16  last error-free reassembled 4-digit hex value.
REQ-007 frame_valid  output  1  one-cycle pulse when value is updated.
REQ-008 frame_err  output  1  one-cycle pulse when a frame completes containing an undecodable glyph.
REQ-009 digit_seen  output  4  digits captured so far in the current frame; bit order as an_in.

Function
REQ-010 seg_in and an_in SHALL be registered once before any use; all timing below counts from the registered sample.
REQ-011 An anode sample is legal only if exactly one bit of an_in is low; all-high or multiple-low samples SHALL be ignored and SHALL clear the settle counter.
REQ-012 State machine SHALL be WAIT -> SETTLE -> HOLD -> WAIT.
REQ-013 WAIT: on a legal sample, go to SETTLE with settle count = 1.
REQ-014 SETTLE: count increments while {an,seg} equals the previous sample; any change restarts the count at 1 (legal) or returns to WAIT (illegal).
REQ-015 When the count reaches SETTLE_CYCLES, the digit SHALL be captured into that position's slot, its digit_seen bit set, and the FSM SHALL enter HOLD.
REQ-016 HOLD: no further capture; any sample change returns to WAIT, or to SETTLE with count 1 if the new sample is legal. A digit is therefore captured at most once per dwell.
REQ-017 Glyph table (active-low, a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-018 Any pattern not in REQ-017 SHALL set a frame-local error flag and store nibble 0 in that slot.
REQ-019 Re-capturing an already-seen position before frame completion SHALL overwrite its nibble; the error flag is not cleared.
REQ-020 The cycle after digit_seen becomes 4'b1111: if there is no error, value loads all four slots and frame_valid pulses; otherwise value holds and frame_err pulses.
REQ-021 In that same cycle, digit_seen and the error flag SHALL clear. A capture in that cycle counts toward the next frame.
REQ-022 frame_valid and frame_err SHALL never assert together.
REQ-023 The settle counter SHALL saturate and never wrap.

Reset
REQ-024 While rst is low: value=16'h0000, frame_valid=0, frame_err=0, digit_seen=4'b0000, FSM=WAIT, settle count=0, sample registers=all-ones (blank).
REQ-025 Reset asserted mid-frame SHALL discard partial digits. The first frame after release starts empty.

Structure
REQ-026 Shared package seg7_pkg SHALL hold the 16 glyph constants, the FSM state enum and the anode one-hot constants.
REQ-027 Glyph lookup SHALL be the combinational sub-module seg7_glyph_decode, with 7-bit pattern in and {valid, 4-bit nibble} out.
REQ-028 Target size is 120-400 lines of RTL. There SHALL be no other clocks or latches.

Verification
REQ-029 Scan 1,2,3,4 on an_in 0111,1011,1101,1110, dwell 8 cycles each -> one frame_valid pulse, value=16'h1234.
REQ-030 Scan A,b,C,d, but insert a 2-cycle glitch pattern 1111111 on digit 2 before its stable glyph -> value=16'hABCD, no frame_err.
REQ-031 Digit 1 shows 1111110 (undecodable) -> frame_err pulse, value keeps its previous 16'h1234, digit_seen clears.
REQ-032 Anodes 0011 or 1111 held for 20 cycles -> no capture, digit_seen unchanged.
REQ-033 Assert rst after 2 of 4 digits are captured, then release and scan F,0,0,F -> digit_seen=0 during reset, then value=16'hF00F with exactly one frame_valid.
REQ-034 Dwell of exactly SETTLE_CYCLES-1 samples per digit -> no capture. Dwell of exactly SETTLE_CYCLES -> capture.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment frame decoder:
// glyph patterns (active-low a..g), anode one-hot-low codes and FSM states.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    // Entry [i] holds the pattern that displays hex digit i.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    localparam logic [3:0] AN_DIGIT0 = 4'b1110;
    localparam logic [3:0] AN_DIGIT1 = 4'b1101;
    localparam logic [3:0] AN_DIGIT2 = 4'b1011;
    localparam logic [3:0] AN_DIGIT3 = 4'b0111;
    localparam logic [3:0] AN_BLANK  = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] pos;
    } anode_t;

    function automatic anode_t decode_anode(input logic [3:0] an);
        anode_t r;
        r = '{legal: 1'b1, pos: 2'd0};
        case (an)
            AN_DIGIT0: r.pos = 2'd0;
            AN_DIGIT1: r.pos = 2'd1;
            AN_DIGIT2: r.pos = 2'd2;
            AN_DIGIT3: r.pos = 2'd3;
            default:   r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph lookup: a 7-bit active-low pattern becomes a hex
// nibble, with valid low for any pattern outside the glyph table.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] nibble
);

    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        valid  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPH_TABLE[i]) begin
                valid  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Reassembles a multiplexed 4-digit seven-segment display back into a
// 16-bit hex value by sampling each digit once it has been stable long enough.
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  digit_seen
);

    localparam logic [7:0] SETTLE_TARGET = 8'(SETTLE_CYCLES);

    logic [6:0]       seg_q;
    logic [3:0]       an_q;
    logic [6:0]       trk_seg;
    logic [3:0]       trk_an;
    state_t           state;
    logic [7:0]       settle_cnt;
    logic [3:0][3:0]  slots;
    logic             err_flag;

    anode_t           sample_an;
    logic             same;
    logic [7:0]       cnt_inc;
    logic             capture;
    logic             glyph_valid;
    logic [3:0]       glyph_nibble;
    logic             frame_done;
    logic [3:0]       seen_base;
    logic             err_base;

    seg7_glyph_decode u_glyph (
        .pattern (seg_q),
        .valid   (glyph_valid),
        .nibble  (glyph_nibble)
    );

    // Input pipeline: reset to blank so nothing is captured out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q <= SEG_BLANK;
            an_q  <= AN_BLANK;
        end else begin
            seg_q <= seg_in;
            an_q  <= an_in;
        end
    end

    // NOTE: combinational logic uses blocking '=', clocked state uses '<='
    // so every register samples values from before the edge.
    always_comb begin
        sample_an = decode_anode(an_q);
        same      = ({an_q, seg_q} == {trk_an, trk_seg});
        cnt_inc   = (settle_cnt == 8'hFF) ? settle_cnt : settle_cnt + 8'd1;
        capture   = (state == ST_SETTLE) && same && (cnt_inc == SETTLE_TARGET);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_WAIT;
            settle_cnt <= 8'd0;
            trk_seg    <= SEG_BLANK;
            trk_an     <= AN_BLANK;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (sample_an.legal) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= 8'd1;
                        trk_seg    <= seg_q;
                        trk_an     <= an_q;
                    end else begin
                        settle_cnt <= 8'd0;
                    end
                end
                ST_SETTLE, ST_HOLD: begin
                    if (same) begin
                        if (state == ST_SETTLE) begin
                            settle_cnt <= cnt_inc;
                            if (capture) state <= ST_HOLD;
                        end
                    end else if (sample_an.legal) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= 8'd1;
                        trk_seg    <= seg_q;
                        trk_an     <= an_q;
                    end else begin
                        state      <= ST_WAIT;
                        settle_cnt <= 8'd0;
                    end
                end
                default: begin
                    state      <= ST_WAIT;
                    settle_cnt <= 8'd0;
                end
            endcase
        end
    end

    // A full frame is retired one cycle after it fills; a capture in that
    // same cycle starts the next frame instead of being lost.
    always_comb begin
        frame_done = (digit_seen == 4'b1111);
        seen_base  = frame_done ? 4'b0000 : digit_seen;
        err_base   = frame_done ? 1'b0    : err_flag;
    end

    // NOTE: the four nibble slots are reset alongside the flags; they are
    // only 16 flops and a clean reset keeps stale digits out of later frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value       <= 16'h0000;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            digit_seen  <= 4'b0000;
            err_flag    <= 1'b0;
            slots       <= '0;
        end else begin
            frame_valid <= frame_done && !err_flag;
            frame_err   <= frame_done && err_flag;
            if (frame_done && !err_flag) value <= slots;

            if (capture) begin
                slots[sample_an.pos]      <= glyph_valid ? glyph_nibble : 4'h0;
                digit_seen                <= seen_base | (4'b0001 << sample_an.pos);
                err_flag                  <= err_base | !glyph_valid;
            end else begin
                digit_seen <= seen_base;
                err_flag   <= err_base;
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Self-checking bench for seg7_frame_decoder: directed scenarios followed by
// randomized scans, compared against a run-length reference model.
module tb_seg7_frame_decoder;

    localparam int S = 4;

    localparam logic [3:0] AN3 = 4'b0111;
    localparam logic [3:0] AN2 = 4'b1011;
    localparam logic [3:0] AN1 = 4'b1101;
    localparam logic [3:0] AN0 = 4'b1110;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] value;
    logic        frame_valid;
    logic        frame_err;
    logic [3:0]  digit_seen;

    seg7_frame_decoder #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .value       (value),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .digit_seen  (digit_seen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model state: slot[p] is the nibble for anode bit p.
    logic [3:0]  m_slots [4];
    logic [3:0]  m_seen;
    logic        m_err;
    logic [15:0] m_value;
    logic [10:0] m_last;
    int          m_run;
    int          exp_valid = 0;
    int          exp_errp  = 0;

    int obs_valid = 0;
    int obs_errp  = 0;
    int overlap   = 0;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) obs_valid++;
        if (frame_err === 1'b1) obs_errp++;
        if (frame_valid === 1'b1 && frame_err === 1'b1) overlap++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int anode_pos(input logic [3:0] an);
        int n = 0;
        int p = -1;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                n++;
                p = i;
            end
        end
        return (n == 1) ? p : -1;
    endfunction

    function automatic int glyph_of(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_slots[i] = 4'h0;
        m_seen  = 4'b0000;
        m_err   = 1'b0;
        m_value = 16'h0000;
        m_last  = {4'hF, BLANK};
        m_run   = 0;
    endtask

    // One sampled cycle of display activity. A digit is taken when its
    // identical run reaches exactly S samples; a full frame is retired on
    // the following sample, before that sample's own capture.
    task automatic model_step(input logic [3:0] an, input logic [6:0] seg);
        int p;
        int g;
        if (m_seen == 4'hF) begin
            if (!m_err) begin
                m_value = {m_slots[3], m_slots[2], m_slots[1], m_slots[0]};
                exp_valid++;
            end else begin
                exp_errp++;
            end
            m_seen = 4'b0000;
            m_err  = 1'b0;
        end
        if ({an, seg} == m_last) m_run++;
        else begin
            m_last = {an, seg};
            m_run  = 1;
        end
        p = anode_pos(an);
        if (p >= 0 && m_run == S) begin
            g = glyph_of(seg);
            m_slots[p] = (g >= 0) ? 4'(g) : 4'h0;
            if (g < 0) m_err = 1'b1;
            m_seen[p] = 1'b1;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            an_in  = an;
            seg_in = seg;
            model_step(an, seg);
        end
    endtask

    task automatic scan4(input logic [6:0] g3, input logic [6:0] g2,
                         input logic [6:0] g1, input logic [6:0] g0, input int dwell);
        drive(AN3, g3, dwell);
        drive(AN2, g2, dwell);
        drive(AN1, g1, dwell);
        drive(AN0, g0, dwell);
    endtask

    task automatic checkpoint(input string tag);
        drive(4'hF, BLANK, 4);
        #1;
        check({tag, "_value"}, 32'(value), 32'(m_value));
        check({tag, "_seen"}, 32'(digit_seen), 32'(m_seen));
        check({tag, "_nvalid"}, obs_valid, exp_valid);
        check({tag, "_nerr"}, obs_errp, exp_errp);
    endtask

    initial begin
        int v0;
        int e0;
        logic [6:0] g;
        logic [6:0] bad;
        logic [3:0] an_list [4];

        an_list = '{AN0, AN1, AN2, AN3};
        model_reset();
        rst    = 1'b0;
        an_in  = 4'hF;
        seg_in = BLANK;
        repeat (3) @(negedge clk);
        #1;
        check("reset_value", 32'(value), 32'h0);
        check("reset_seen", 32'(digit_seen), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);
        check("reset_fe", 32'(frame_err), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Plain scan of 1,2,3,4.
        v0 = obs_valid;
        scan4(glyph[1], glyph[2], glyph[3], glyph[4], 8);
        checkpoint("scan1234");
        check("scan1234_const", 32'(value), 32'h1234);
        check("scan1234_one_pulse", obs_valid - v0, 1);

        // Undecodable glyph on digit 1 poisons the frame.
        e0 = obs_errp;
        scan4(glyph[1], glyph[2], 7'b1111110, glyph[4], 8);
        checkpoint("baddigit");
        check("baddigit_keep", 32'(value), 32'h1234);
        check("baddigit_err_pulse", obs_errp - e0, 1);
        check("baddigit_seen_clr", 32'(digit_seen), 32'h0);

        // Short blank glitch on digit 2 before its stable glyph.
        e0 = obs_errp;
        drive(AN3, glyph[10], 8);
        drive(AN2, BLANK, 2);
        drive(AN2, glyph[11], 8);
        drive(AN1, glyph[12], 8);
        drive(AN0, glyph[13], 8);
        checkpoint("glitch");
        check("glitch_const", 32'(value), 32'hABCD);
        check("glitch_no_err", obs_errp - e0, 0);

        // Illegal anode patterns never capture.
        drive(AN0, glyph[5], S + 2);
        drive(4'b0011, glyph[8], 20);
        drive(4'b1111, glyph[8], 20);
        checkpoint("illegal_an");
        check("illegal_an_seen", 32'(digit_seen), 32'h1);

        // Dwell boundary: S-1 samples miss, S samples capture.
        drive(AN3, glyph[7], S - 1);
        drive(AN2, glyph[8], S - 1);
        drive(AN1, glyph[9], S - 1);
        checkpoint("dwell_short");
        check("dwell_short_seen", 32'(digit_seen), 32'h1);
        drive(AN3, glyph[7], S);
        drive(AN2, glyph[8], S);
        drive(AN1, glyph[9], S);
        checkpoint("dwell_exact");
        check("dwell_exact_const", 32'(value), 32'h7895);

        // Reset mid-frame discards the partial digits.
        drive(AN3, glyph[15], 8);
        drive(AN2, glyph[0], 8);
        drive(AN1, glyph[1], 2);
        @(negedge clk);
        rst    = 1'b0;
        an_in  = 4'hF;
        seg_in = BLANK;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("midreset_seen", 32'(digit_seen), 32'h0);
        check("midreset_value", 32'(value), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        v0 = obs_valid;
        scan4(glyph[15], glyph[0], glyph[0], glyph[15], 8);
        checkpoint("after_reset");
        check("after_reset_const", 32'(value), 32'hF00F);
        check("after_reset_one_pulse", obs_valid - v0, 1);

        // Randomized scans with glitches, bad glyphs and illegal anodes.
        for (int it = 0; it < 30; it++) begin
            for (int k = 3; k >= 0; k--) begin
                if ($urandom_range(0, 9) == 0)
                    drive(($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1111, 7'($urandom), $urandom_range(1, 5));
                if ($urandom_range(0, 7) == 0)
                    drive(an_list[k], 7'($urandom), $urandom_range(1, S - 1));
                if ($urandom_range(0, 7) == 0) begin
                    bad = 7'($urandom);
                    while (glyph_of(bad) >= 0) bad = 7'($urandom);
                    g = bad;
                end else begin
                    g = glyph[$urandom_range(0, 15)];
                end
                drive(an_list[k], g, $urandom_range(S - 1, S + 3));
            end
            checkpoint($sformatf("rand%0d", it));
        end

        check("never_both_pulses", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
